// File: rtl/fadd_round_pack.sv
// fadd_round_pack: normalize / round / pack stage for the FPU adder and FMA.
// Takes a raw sum (sign, signed unbiased exponent, 48-bit unnormalized
// significand) or a pre-packed special result, and returns an IEEE-754 single
// plus fflags. Single-entry, multi-cycle, valid/ready on both sides.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  request handshake (ready only while idle)
//   sign_i, exp_i, sig_i     raw sum; value = sig_i / 2^46 * 2^exp_i
//   rm_i                     RISC-V rounding mode (101..111 act as RNE)
//   special_i, packed_i,     bypass: packed_i / flags_i returned verbatim;
//   flags_i                  flags_i[4] (NV) is also ORed in on the normal path
//   out_valid_o / out_ready_i result handshake
//   result_o, fflags_o       packed single, {NV, DZ, OF, UF, NX}
//
// Configuration macro FPU_FAST_NORM_EN: when defined, NORM uses a leading-zero
// count and DENORM a barrel shift (one cycle each); otherwise both shift one
// bit per cycle. Results are bit-identical in both builds.
module fadd_round_pack #(
    parameter int EXP_W = 11,
    parameter int SIG_W = 48
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             sign_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [SIG_W-1:0] sig_i,
    input  logic [2:0]       rm_i,
    input  logic             special_i,
    input  logic [31:0]      packed_i,
    input  logic [4:0]       flags_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      result_o,
    output logic [4:0]       fflags_o
);

    // Two guard bits of headroom so carry / left-shift steps never wrap.
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_MIN = EW'(-126);
    localparam logic signed [EW-1:0] ONE     = EW'(1);
    localparam logic signed [EW-1:0] BIAS    = EW'(127);
    localparam logic        [EW-1:0] EXP_OVF = EW'(255);

    typedef enum logic [2:0] {StIdle, StNorm, StDenorm, StRound, StDone} state_e;

    state_e                 state_q;
    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic [SIG_W-1:0]       sig_q;
    logic                   sticky_q;
    logic [2:0]             rm_q;
    logic                   nv_q;
    logic [31:0]            result_q;
    logic [4:0]             fflags_q;

    logic [SIG_W-1:0]       norm_sig, den_sig;
    logic signed [EW-1:0]   norm_exp, den_exp;
    logic                   norm_stk, den_stk;
    state_e                 norm_st;

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign result_o    = result_q;
    assign fflags_o    = fflags_q;

`ifdef FPU_FAST_NORM_EN
    localparam int LZW = $clog2(SIG_W + 1);
    localparam logic signed [EW-1:0] SIG_LEN = EW'(SIG_W);
    logic [LZW-1:0]       lzc;
    logic signed [EW-1:0] dsh;

    always_comb begin
        lzc = LZW'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (sig_q[i]) lzc = LZW'(SIG_W - 1 - i);
        end
        norm_stk = sticky_q;
        if (sig_q[SIG_W-1]) begin
            norm_sig = sig_q >> 1;
            norm_stk = sticky_q | sig_q[0];
            norm_exp = exp_q + ONE;
        end else begin
            // Bit SIG_W-1 is clear, so lzc >= 1; bring the leading one to the hidden bit.
            norm_sig = sig_q << (lzc - LZW'(1));
            norm_exp = exp_q - $signed({{(EW-LZW){1'b0}}, lzc}) + ONE;
        end
        norm_st = (norm_exp < EXP_MIN) ? StDenorm : StRound;

        dsh     = EXP_MIN - exp_q;
        den_exp = EXP_MIN;
        if (dsh >= SIG_LEN) begin
            den_sig = '0;
            den_stk = sticky_q | (|sig_q);
        end else begin
            den_sig = sig_q >> $unsigned(dsh);
            den_stk = sticky_q | (|(sig_q & ~({SIG_W{1'b1}} << $unsigned(dsh))));
        end
    end
`else
    always_comb begin
        norm_sig = sig_q;
        norm_exp = exp_q;
        norm_stk = sticky_q;
        norm_st  = StNorm;
        if (sig_q[SIG_W-1]) begin
            norm_sig = sig_q >> 1;
            norm_stk = sticky_q | sig_q[0];
            norm_exp = exp_q + ONE;
        end else if (!sig_q[SIG_W-2]) begin
            norm_sig = sig_q << 1;
            norm_exp = exp_q - ONE;
        end else begin
            norm_st = (exp_q < EXP_MIN) ? StDenorm : StRound;
        end

        if (sig_q == '0) begin
            // Everything already shifted into sticky; jump straight to the floor.
            den_sig = sig_q;
            den_stk = sticky_q;
            den_exp = EXP_MIN;
        end else begin
            den_sig = sig_q >> 1;
            den_stk = sticky_q | sig_q[0];
            den_exp = exp_q + ONE;
        end
    end
`endif

    // Rounding and packing, consumed only in StRound.
    logic [22:0]    mant;
    logic           guard, stk, lsb, inc, of, nx, uf;
    logic [23:0]    mant_sum;
    logic [EW-1:0]  ebias, exp_fld, exp_fin;
    logic [31:0]    rnd_res;
    logic [4:0]     rnd_flags;

    always_comb begin
        mant  = sig_q[SIG_W-3 -: 23];
        guard = sig_q[SIG_W-26];
        lsb   = sig_q[SIG_W-25];
        stk   = sticky_q | (|sig_q[SIG_W-27:0]);
        case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q & (guard | stk);
            3'b011:  inc = ~sign_q & (guard | stk);
            3'b100:  inc = guard;
            default: inc = guard & (stk | lsb);
        endcase
        mant_sum = {1'b0, mant} + {23'b0, inc};
        ebias    = $unsigned(exp_q + BIAS);
        exp_fld  = sig_q[SIG_W-2] ? ebias : '0;
        // Mantissa carry ripples into the exponent field (subnormal -> min normal).
        exp_fin  = exp_fld + {{(EW-1){1'b0}}, mant_sum[23]};
        of       = (exp_fin >= EXP_OVF);
        nx       = guard | stk;
        uf       = nx & (exp_fin == '0);
        rnd_res  = {sign_q, exp_fin[7:0], mant_sum[22:0]};
        if (of) begin
            nx = 1'b1;
            uf = 1'b0;
            case (rm_q)
                3'b001:  rnd_res = {sign_q, 8'hFE, 23'h7FFFFF};
                3'b010:  rnd_res = sign_q ? {1'b1, 8'hFF, 23'h0} : {1'b0, 8'hFE, 23'h7FFFFF};
                3'b011:  rnd_res = sign_q ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'h0};
                default: rnd_res = {sign_q, 8'hFF, 23'h0};
            endcase
        end
        rnd_flags = {nv_q, 1'b0, of, uf, nx};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            sticky_q <= 1'b0;
            rm_q     <= 3'b0;
            nv_q     <= 1'b0;
            result_q <= '0;
            fflags_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        sign_q   <= sign_i;
                        exp_q    <= EW'($signed(exp_i));
                        sig_q    <= sig_i;
                        sticky_q <= 1'b0;
                        rm_q     <= rm_i;
                        nv_q     <= flags_i[4];
                        if (special_i) begin
                            result_q <= packed_i;
                            fflags_q <= flags_i;
                            state_q  <= StDone;
                        end else begin
                            state_q  <= StNorm;
                        end
                    end
                end
                StNorm: begin
                    if (sig_q == '0) begin
                        result_q <= {sign_q, 31'b0};
                        fflags_q <= {nv_q, 4'b0};
                        state_q  <= StDone;
                    end else begin
                        sig_q    <= norm_sig;
                        exp_q    <= norm_exp;
                        sticky_q <= norm_stk;
                        state_q  <= norm_st;
                    end
                end
                StDenorm: begin
                    sig_q    <= den_sig;
                    exp_q    <= den_exp;
                    sticky_q <= den_stk;
                    if (den_exp == EXP_MIN) state_q <= StRound;
                end
                StRound: begin
                    result_q <= rnd_res;
                    fflags_q <= rnd_flags;
                    state_q  <= StDone;
                end
                StDone: begin
                    if (out_ready_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
